// File: rtl/fft_bitrev_reorder.sv
// Restores natural sample order for frames leaving the 16-point SDF FFT, using a ping-pong register file.
// Readout starts 1 edge after the edge that writes the last input sample; there is no backpressure, so each burst runs N cycles.
module fft_bitrev_reorder #(
    parameter int LOG2N = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic [LOG2N-1:0] out_index,
    output logic [WIDTH-1:0] out_data,
    output logic             frame_err
);
    localparam int N = 1 << LOG2N;

    logic [WIDTH-1:0] mem [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_bank;
    logic [LOG2N-1:0] rd_cnt;
    logic             rd_bank;
    logic             rd_active;
    logic             complete;

    // in_sof forces the sample to index 0 regardless of where the counter is.
    always_comb begin
        wr_idx  = in_sof ? '0 : wr_cnt;
        wr_addr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            wr_addr[i] = wr_idx[LOG2N-1-i];
        end
        complete = in_valid && (&wr_idx);
    end

    // Storage has no reset: stale contents are always overwritten before they are read.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[{wr_bank, wr_addr}] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_active <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= in_valid && in_sof && (wr_cnt != '0);
            if (in_valid) begin
                wr_cnt <= wr_idx + 1'b1;
            end

            if (rd_active) begin
                out_valid <= 1'b1;
                out_sof   <= (rd_cnt == '0);
                out_index <= rd_cnt;
                out_data  <= mem[{rd_bank, rd_cnt}];
                rd_cnt    <= rd_cnt + 1'b1;
                if (&rd_cnt) begin
                    rd_active <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
            end

            // A completion on the same edge as the last read restarts the reader without a bubble.
            if (complete) begin
                wr_bank   <= ~wr_bank;
                rd_bank   <= wr_bank;
                rd_cnt    <= '0;
                rd_active <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: reordering, latency, back-to-back frames, gaps, frame errors, reset abort.
module tb_fft_bitrev_reorder;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_sof;
    logic [3:0]  out_index;
    logic [23:0] out_data;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    fft_bitrev_reorder #(.LOG2N(4), .WIDTH(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_index (out_index),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] br(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [23:0] fd(input int f, input int j);
        return {4'h1, 4'(f), 16'(j)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [23:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic [3:0] idx, input logic [23:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
        chk({tag, "_sof"},   32'(out_sof),   32'(s));
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 24'h0);
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sof",   32'(out_sof),   0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_err",   32'(frame_err), 0);
        reset = 1'b0;

        // Test 1: ramp frame
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, j == 0, 24'(j));
            tick();
            chk($sformatf("t1_in%0d_valid", j), 32'(out_valid), 0);
        end
        drive(1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_out($sformatf("t1_k%0d", k), k == 0, 4'(k), 24'(br(4'(k))));
        end
        tick();
        chk("t1_end_valid", 32'(out_valid), 0);
        chk("t1_end_sof",   32'(out_sof),   0);
        chk("t1_hold_index", 32'(out_index), 15);
        chk("t1_hold_data",  32'(out_data),  15);

        // Test 2: impulse at input 1 lands at natural index 8
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, j == 0, (j == 1) ? 24'h400000 : 24'h0);
            tick();
        end
        drive(1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_out($sformatf("t2_k%0d", k), k == 0, 4'(k), (k == 8) ? 24'h400000 : 24'h0);
        end

        // Test 3: three back-to-back frames
        for (int c = 0; c < 65; c++) begin
            if (c < 48) drive(1'b1, (c % 16) == 0, fd(c / 16, c % 16));
            else        drive(1'b0, 1'b0, 24'h0);
            tick();
            if (c >= 16 && c < 64)
                chk_out($sformatf("t3_c%0d", c), ((c - 16) % 16) == 0, 4'((c - 16) % 16),
                        fd((c - 16) / 16, int'(br(4'((c - 16) % 16)))));
            else
                chk($sformatf("t3_c%0d_valid", c), 32'(out_valid), 0);
        end

        // Test 4: input every other cycle
        for (int c = 0; c < 48; c++) begin
            if ((c % 2) == 0 && c < 32) drive(1'b1, c == 0, 24'hB00000 + 24'(c / 2));
            else                        drive(1'b0, 1'b0, 24'h0);
            tick();
            if (c >= 31 && c < 47)
                chk_out($sformatf("t4_c%0d", c), c == 31, 4'(c - 31), 24'hB00000 + 24'(br(4'(c - 31))));
            else
                chk($sformatf("t4_c%0d_valid", c), 32'(out_valid), 0);
        end

        // Test 5: in_sof at j=5 discards the partial frame
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, j == 0, 24'hC00000 + 24'(j));
            tick();
            chk($sformatf("t5_p%0d_err", j), 32'(frame_err), 0);
            chk($sformatf("t5_p%0d_valid", j), 32'(out_valid), 0);
        end
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, n == 0, 24'hD00000 + 24'(n));
            tick();
            chk($sformatf("t5_n%0d_err", n), 32'(frame_err), 32'(n == 0));
            chk($sformatf("t5_n%0d_valid", n), 32'(out_valid), 0);
        end
        drive(1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_out($sformatf("t5_k%0d", k), k == 0, 4'(k), 24'hD00000 + 24'(br(4'(k))));
        end
        tick();
        chk("t5_end_valid", 32'(out_valid), 0);

        // Test 6: reset mid-burst, with a partial next frame in flight
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, j == 0, 24'hE00000 + 24'(j));
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 24'h5A5A5A);
            tick();
            chk_out($sformatf("t6_k%0d", k), k == 0, 4'(k), 24'hE00000 + 24'(br(4'(k))));
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 24'h0);
        tick();
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_sof",   32'(out_sof),   0);
        chk("t6_rst_index", 32'(out_index), 0);
        chk("t6_rst_data",  32'(out_data),  0);
        chk("t6_rst_err",   32'(frame_err), 0);
        reset = 1'b0;
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, j == 0, 24'hF00000 + 24'(j));
            tick();
            chk($sformatf("t6_in%0d_valid", j), 32'(out_valid), 0);
            chk($sformatf("t6_in%0d_err", j), 32'(frame_err), 0);
        end
        drive(1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_out($sformatf("t6_f_k%0d", k), k == 0, 4'(k), 24'hF00000 + 24'(br(4'(k))));
        end
        tick();
        chk("t6_end_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
